seg_disp_scheduler: RTL and testbench
=====================================

Name: seg_disp_scheduler

Overview:
Time-shares the two-digit 7-segment display between NUM_REQ requesters, such as PS software, camera status and error codes. Each requester posts an 8-bit value with a req/grant handshake. A round-robin arbiter picks one request, latches its value and holds it on the display for HOLD_CYCLES clocks. The block drives the data_in byte of the existing 7-seg driver (ctrl_7seg) and sits between the requesters and that driver.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
HOLD_CYCLES, 50000000, minimum display time per grant in clk cycles; must be >= 1.
IDLE_VALUE, 8'h00, value on disp_data after reset, before the first grant.

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  reset, synchronous, active-low
req  in  NUM_REQ  per-requester request level
req_data  in  NUM_REQ*8  packed values; requester i uses bits [8i+7:8i]
grant  out  NUM_REQ  one-hot, one-cycle acknowledge of the accepted request
disp_data  out  8  byte to the 7-seg driver data_in
disp_owner  out  OW  index of the current/last owner; OW = max(1, clog2(NUM_REQ))
disp_valid  out  1  high while a hold window is active
busy  out  1  high in SHOW state

Behaviour:
- Reset (rstn=0 at a clk edge): state=IDLE, grant=0, disp_data=IDLE_VALUE, disp_owner=0, disp_valid=0, busy=0, hold counter=0.
  - RR pointer last=NUM_REQ-1, so requester 0 wins first.
  - Reset overrides any activity, including mid-SHOW.
- All outputs are registered.
- State IDLE:
  - If |req=1 at edge N, select winner w = first set bit searching from last+1 upward, wrapping modulo NUM_REQ.
  - At edge N the block: registers grant[w]=1 for one cycle; latches disp_data=req_data[w] sampled at edge N; sets disp_owner=w and last=w; sets hold counter=HOLD_CYCLES-1; sets disp_valid=1 and busy=1; moves to SHOW.
  - Latency is 1 cycle from req visible to grant/disp_data update.
- State SHOW:
  - Counter decrements each cycle. req is ignored; there is no preemption.
  - At the edge where counter==0:
    - If |req=1, arbitrate as in IDLE in that same edge (back-to-back). Grant, new data and counter reload all occur together, so disp_valid stays 1 with no gap.
    - Otherwise go to IDLE with disp_valid=0 and busy=0.
- disp_data is held after the hold window ends. The display keeps the last value until the next grant; IDLE_VALUE appears only after reset.
- Handshake rules:
  - A requester holds req and req_data stable until it sees grant.
  - It may deassert req in the grant cycle.
  - req still high one cycle after grant counts as a new request and re-enters arbitration fairly, behind the other pending requesters.
  - Withdrawing req before grant is legal; the request is simply not served.
- grant is never asserted in a cycle where the corresponding req was 0 at the sampling edge. At most one grant bit is set per cycle.
- HOLD_CYCLES=1: counter loads 0, so the window is exactly 1 cycle and arbitration is possible every cycle.
- Counter width: clog2(HOLD_CYCLES+1). No wrap; it stops at 0 in IDLE.

Decomposition:
- Shared package seg_sched_pkg:
  - state encoding: ST_IDLE=1'b0, ST_SHOW=1'b1
  - default HOLD_CYCLES and IDLE_VALUE constants
  - clog2 function
- Sub-module rr_arbiter (parameter N), purely combinational. Inputs req[N] and last[OW]; outputs one-hot gnt[N], index idx[OW], any. The scheduler registers its outputs.

Test Plan:
- HOLD_CYCLES=4, req=4'b0100 with data 8'h3C for one cycle, then drop: grant=4'b0100 one cycle later; disp_data=8'h3C, disp_owner=2; disp_valid high exactly 4 cycles, then IDLE; disp_data stays 8'h3C.
- req=4'b1111 held, each requester dropping its req on its own grant: grants in order 0,1,2,3, spaced 4 cycles apart; disp_valid continuously 1 until the last window ends.
- Requester 1 keeps req high permanently while requester 3 requests: grants alternate 1,3,1,3; neither starves.
- rstn=0 two cycles into SHOW: next edge grant=0, disp_valid=0, busy=0, disp_data=8'h00, disp_owner=0; the next req=4'b0001 is granted 1 cycle later.
- req[2] pulsed while in SHOW and withdrawn before the window ends: no grant[2] ever; block returns to IDLE.
- HOLD_CYCLES=1, req=4'b0011 held: grant toggles 0,1,0,1 every cycle; disp_data updates every cycle.

Source files
------------

// File: rtl/seg_sched_pkg.sv
// Shared definitions for the 7-segment display scheduler: state encoding,
// default parameter values and width helpers.
package seg_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_e;

  localparam int unsigned DEF_HOLD_CYCLES = 50_000_000;
  localparam logic [7:0]  DEF_IDLE_VALUE  = 8'h00;

  // Ceiling log2; clog2(0) = clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Width of an index into n items, at least one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req starting at last+1 and wrapping modulo N; the first set bit wins.
// Ports:
//   req  - request vector
//   last - index of the previous winner (priority starts just above it)
//   gnt  - one-hot winner
//   idx  - binary index of the winner
//   any  - at least one request present
module rr_arbiter
  import seg_sched_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned OW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [OW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [OW-1:0] idx,
  output logic          any
);

  int unsigned c;

  // Rotating priority scan: offsets 1..N from last, first hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      c = 32'(last) + k;
      if (c >= N) c = c - N;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = OW'(c);
      end
    end
  end

endmodule

// File: rtl/seg_disp_scheduler.sv
// Time-shares the two-digit 7-segment display between NUM_REQ requesters.
// A round-robin winner's byte is latched and held for HOLD_CYCLES clocks;
// back-to-back grants keep disp_valid high without a gap.
// Ports:
//   clk, rstn   - clock, synchronous active-low reset
//   req         - per-requester request level
//   req_data    - packed request bytes, requester i at [8i+7:8i]
//   grant       - one-cycle one-hot acknowledge
//   disp_data   - byte for the 7-seg driver data_in
//   disp_owner  - index of the current/last owner
//   disp_valid  - hold window active
//   busy        - in SHOW state
module seg_disp_scheduler
  import seg_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter logic [7:0]  IDLE_VALUE  = DEF_IDLE_VALUE,
  localparam int unsigned OW         = idx_width(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           disp_data,
  output logic [OW-1:0]        disp_owner,
  output logic                 disp_valid,
  output logic                 busy
);

  localparam int unsigned CW = (clog2(HOLD_CYCLES + 1) < 1) ? 1 : clog2(HOLD_CYCLES + 1);

  state_e              state;
  logic [CW-1:0]       cnt;
  logic [OW-1:0]       last;

  logic [NUM_REQ-1:0]  arb_gnt_c;
  logic [OW-1:0]       arb_idx_c;
  logic                arb_any_c;
  logic                arb_fire_c;

  rr_arbiter #(
    .N  (NUM_REQ),
    .OW (OW)
  ) u_arb (
    .req  (req),
    .last (last),
    .gnt  (arb_gnt_c),
    .idx  (arb_idx_c),
    .any  (arb_any_c)
  );

  // Arbitration happens in IDLE or on the last cycle of a hold window.
  assign arb_fire_c = arb_any_c && ((state == ST_IDLE) || (cnt == '0));

  // Scheduler state, hold counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      last       <= OW'(NUM_REQ - 1);
      grant      <= '0;
      disp_data  <= IDLE_VALUE;
      disp_owner <= '0;
      disp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      grant <= '0;
      if (arb_fire_c) begin
        grant      <= arb_gnt_c;
        disp_data  <= req_data[32'(arb_idx_c) * 8 +: 8];
        disp_owner <= arb_idx_c;
        last       <= arb_idx_c;
        cnt        <= CW'(HOLD_CYCLES - 1);
        state      <= ST_SHOW;
        disp_valid <= 1'b1;
        busy       <= 1'b1;
      end else if (state == ST_SHOW) begin
        if (cnt == '0) begin
          // Window over with nothing pending; disp_data keeps the last byte.
          state      <= ST_IDLE;
          disp_valid <= 1'b0;
          busy       <= 1'b0;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_disp_scheduler.sv
// Self-checking bench for seg_disp_scheduler: instance A (HOLD_CYCLES=4) is
// checked through a grant scoreboard plus direct timing checks; instance B
// (HOLD_CYCLES=1) checks every-cycle arbitration.
module tb_seg_disp_scheduler;

  localparam int unsigned NR = 4;

  logic          clk;
  logic          rstn;

  logic [NR-1:0]   req_a;
  logic [NR*8-1:0] req_data_a;
  logic [NR-1:0]   grant_a;
  logic [7:0]      disp_data_a;
  logic [1:0]      disp_owner_a;
  logic            disp_valid_a;
  logic            busy_a;

  logic [NR-1:0]   req_b;
  logic [NR*8-1:0] req_data_b;
  logic [NR-1:0]   grant_b;
  logic [7:0]      disp_data_b;
  logic [1:0]      disp_owner_b;
  logic            disp_valid_b;
  logic            busy_b;

  typedef struct {
    int unsigned idx;
    logic [7:0]  data;
    int unsigned gap;   // expected cycles since previous grant, 0 = don't care
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  int unsigned last_cyc = 0;
  logic [NR-1:0] auto_drop = '1;

  seg_disp_scheduler #(
    .NUM_REQ     (NR),
    .HOLD_CYCLES (4),
    .IDLE_VALUE  (8'h00)
  ) u_dut_a (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req_a),
    .req_data   (req_data_a),
    .grant      (grant_a),
    .disp_data  (disp_data_a),
    .disp_owner (disp_owner_a),
    .disp_valid (disp_valid_a),
    .busy       (busy_a)
  );

  seg_disp_scheduler #(
    .NUM_REQ     (NR),
    .HOLD_CYCLES (1),
    .IDLE_VALUE  (8'h00)
  ) u_dut_b (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req_b),
    .req_data   (req_data_b),
    .grant      (grant_b),
    .disp_data  (disp_data_b),
    .disp_owner (disp_owner_b),
    .disp_valid (disp_valid_b),
    .busy       (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Grant monitor for instance A: pops the scoreboard on every grant and
  // plays the requesters that drop req once granted.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (grant_a != '0) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_grant", 32'(grant_a), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("sb_grant", 32'(grant_a), 32'h1 << e.idx);
        check_eq("sb_data", 32'(disp_data_a), 32'(e.data));
        check_eq("sb_owner", 32'(disp_owner_a), e.idx);
        if (e.gap != 0) check_eq("sb_gap", cyc - last_cyc, e.gap);
      end
      last_cyc = cyc;
      req_a = req_a & ~(grant_a & auto_drop);
    end
  end

  task automatic push_exp(input int unsigned idx, input logic [7:0] data, input int unsigned gap);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    e.gap  = gap;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_grant", 32'(grant_a), 32'h0);
    check_eq("rst_valid", 32'(disp_valid_a), 32'h0);
    check_eq("rst_busy", 32'(busy_a), 32'h0);
    check_eq("rst_data", 32'(disp_data_a), 32'h00);
    check_eq("rst_owner", 32'(disp_owner_a), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Counts consecutive samples with disp_valid high, starting now.
  task automatic count_valid(output int unsigned n);
    n = 0;
    while (disp_valid_a && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int unsigned k;
    k = 0;
    while (busy_a && k < 200) begin
      k++;
      @(posedge clk);
      #1;
    end
    check_eq(tag, 32'(busy_a), 32'h0);
  endtask

  initial begin
    int unsigned n;
    int unsigned k;
    rstn       = 1'b0;
    req_a      = '0;
    req_data_a = '0;
    req_b      = '0;
    req_data_b = '0;

    do_reset();
    check_eq("rst_b_data", 32'(disp_data_b), 32'h00);

    // Single one-cycle request from requester 2.
    @(negedge clk);
    req_a[2] = 1'b1;
    req_data_a[23:16] = 8'h3C;
    push_exp(2, 8'h3C, 0);
    @(posedge clk);
    #1;
    check_eq("s1_grant", 32'(grant_a), 32'h4);
    check_eq("s1_data", 32'(disp_data_a), 32'h3C);
    check_eq("s1_owner", 32'(disp_owner_a), 32'h2);
    count_valid(n);
    check_eq("s1_valid_len", n, 4);
    check_eq("s1_busy_after", 32'(busy_a), 32'h0);
    check_eq("s1_data_held", 32'(disp_data_a), 32'h3C);

    // All four requesters, each dropping on its own grant.
    do_reset();
    @(negedge clk);
    req_data_a = 32'h13121110;
    req_a = 4'b1111;
    push_exp(0, 8'h10, 0);
    push_exp(1, 8'h11, 4);
    push_exp(2, 8'h12, 4);
    push_exp(3, 8'h13, 4);
    @(posedge clk);
    #1;
    check_eq("s2_first_grant", 32'(grant_a), 32'h1);
    count_valid(n);
    check_eq("s2_valid_len", n, 16);
    check_eq("s2_sb_empty", sb.size(), 0);

    // Requesters 1 and 3 both hold req: grants must alternate.
    @(negedge clk);
    auto_drop = 4'b0101;
    req_data_a = 32'hB3_00_A1_00;
    req_a = 4'b1010;
    push_exp(1, 8'hA1, 0);
    push_exp(3, 8'hB3, 4);
    push_exp(1, 8'hA1, 4);
    push_exp(3, 8'hB3, 4);
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      k++;
      @(negedge clk);
    end
    check_eq("s3_sb_drained", sb.size(), 0);
    req_a = '0;
    auto_drop = '1;
    wait_idle("s3_idle");

    // Reset two cycles into a SHOW window.
    @(negedge clk);
    req_data_a = 32'h005A0000;
    req_a[2] = 1'b1;
    push_exp(2, 8'h5A, 0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    do_reset();
    @(negedge clk);
    req_data_a = 32'h00000077;
    req_a[0] = 1'b1;
    push_exp(0, 8'h77, 0);
    @(posedge clk);
    #1;
    check_eq("s4_grant", 32'(grant_a), 32'h1);
    check_eq("s4_data", 32'(disp_data_a), 32'h77);
    wait_idle("s4_idle");

    // Request withdrawn during SHOW is never served.
    @(negedge clk);
    req_data_a = 32'h00EE0001;
    req_a[0] = 1'b1;
    push_exp(0, 8'h01, 0);
    @(posedge clk);
    #1;
    check_eq("s5_grant", 32'(grant_a), 32'h1);
    @(negedge clk);
    req_a[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    req_a[2] = 1'b0;
    wait_idle("s5_idle");
    repeat (3) @(posedge clk);
    #1;
    check_eq("s5_no_grant", 32'(grant_a), 32'h0);
    check_eq("s5_sb_empty", sb.size(), 0);
    check_eq("s5_data_held", 32'(disp_data_a), 32'h01);

    // HOLD_CYCLES=1: grants alternate every cycle.
    @(negedge clk);
    req_data_b = 32'h0000C1C0;
    req_b = 4'b0011;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check_eq("s6_grant", 32'(grant_b), (i % 2 == 0) ? 32'h1 : 32'h2);
      check_eq("s6_data", 32'(disp_data_b), (i % 2 == 0) ? 32'hC0 : 32'hC1);
      check_eq("s6_valid", 32'(disp_valid_b), 32'h1);
    end
    @(negedge clk);
    req_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("s6_idle", 32'(busy_b), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
